// File: rtl/number_load_fifo.sv
// First-word-fall-through FIFO fed by a load strobe. It keeps an occupancy count,
// a full flag and a sticky overflow flag that records any dropped load.
module number_load_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] number,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             overflow
);

  // Handshake: a word leaves on a rising edge where out_valid && out_ready.
  // out_valid depends only on stored state, never on out_ready.
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             pop;
  logic             wr_en;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == FULL_COUNT);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;

  always_comb begin
    pop        = out_valid & out_ready;
    // A pop frees a slot on the same edge, so a full FIFO can still take a word.
    wr_en      = load & (~full | pop);
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = number;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (wr_en && !pop) begin
        count_d = count_q + (AW+1)'(1);
      end else if (pop && !wr_en) begin
        count_d = count_q - (AW+1)'(1);
      end
      if (load && !wr_en) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_number_load_fifo.sv
// Bench for number_load_fifo: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the FIFO.
module tb_number_load_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk;
  logic          rst;
  logic          load;
  logic [W-1:0]  number;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;

  logic [W-1:0]  exp_q[$];
  bit            exp_ovf;
  int            checks;
  int            passed;
  int            failed;

  number_load_fifo #(.WIDTH(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .number    (number),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every visible output against the model queue
  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    check({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    if (exp_q.size() != 0) check({tag, "_data"}, 32'(out_data), 32'(exp_q[0]));
  endtask

  // Advance one edge: model reacts to the current inputs, then DUT is sampled
  task automatic step(input string tag);
    bit do_pop;
    bit do_push;
    if (clear) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      do_pop  = (exp_q.size() != 0) && out_ready;
      do_push = load && ((exp_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(number);
      else if (load) exp_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  // Driver
  task automatic drive(input string tag, input bit l, input logic [W-1:0] n,
                       input bit r, input bit c);
    load      = l;
    number    = n;
    out_ready = r;
    clear     = c;
    step(tag);
  endtask

  initial begin
    checks = 0; passed = 0; failed = 0;
    exp_ovf = 1'b0;
    rst = 1'b1; load = 1'b0; number = '0; clear = 1'b0; out_ready = 1'b0;
    #1;
    check_state("reset_async");
    @(posedge clk);
    #1;
    check_state("reset_edge");
    rst = 1'b0;

    // Single word
    drive("single_load", 1'b1, 8'hA5, 1'b0, 1'b0);
    check("single_data", 32'(out_data), 32'h0A5);
    check("single_cnt", 32'(count), 32'd1);
    drive("single_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    check("single_empty", 32'(out_valid), 32'd0);

    // Fill, overflow, drain
    for (int i = 1; i <= 8; i++) drive("fill", 1'b1, W'(i), 1'b0, 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_cnt", 32'(count), 32'd8);
    drive("ovf_load", 1'b1, 8'h09, 1'b0, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", 32'(out_data), 32'(i));
      drive("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain_ovf_sticky", 32'(overflow), 32'd1);

    // Full pass-through
    drive("clr", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) drive("refill", 1'b1, W'(i), 1'b0, 1'b0);
    drive("pass", 1'b1, 8'h10, 1'b1, 1'b0);
    check("pass_cnt", 32'(count), 32'd8);
    check("pass_ovf", 32'(overflow), 32'd0);
    check("pass_head", 32'(out_data), 32'h02);
    for (int i = 0; i < 7; i++) drive("pass_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    check("pass_last", 32'(out_data), 32'h10);
    drive("pass_final", 1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap with continuous streaming
    for (int i = 0; i < 20; i++) begin
      drive("stream", 1'b1, W'(i), 1'b1, 1'b0);
      check("stream_head", 32'(out_data), 32'(i));
      check("stream_cnt_le1", 32'(count <= 1), 32'd1);
    end
    drive("stream_end", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-burst, with load held through reset
    for (int i = 0; i < 5; i++) drive("pre_rst", 1'b1, W'(8'h30 + i), 1'b0, 1'b0);
    load = 1'b1; number = 8'h55; out_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check_state("rst_async");
    @(posedge clk);
    #1;
    check_state("rst_held");
    #2;
    rst = 1'b0;
    drive("post_rst", 1'b1, 8'h66, 1'b0, 1'b0);
    check("post_rst_head", 32'(out_data), 32'h66);
    drive("post_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Clear with a simultaneous load
    for (int i = 0; i < 3; i++) drive("pre_clr", 1'b1, W'(8'h40 + i), 1'b0, 1'b0);
    drive("clr_load", 1'b1, 8'hEE, 1'b1, 1'b1);
    check("clr_cnt", 32'(count), 32'd0);
    drive("clr_after", 1'b0, 8'h00, 1'b0, 1'b0);

    // Empty read
    for (int i = 0; i < 4; i++) drive("empty_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic: a filling phase, a balanced phase, a draining phase
    for (int i = 0; i < 600; i++) begin
      int rdy_pct;
      rdy_pct = (i < 200) ? 20 : ((i < 400) ? 60 : 90);
      drive("rand", 1'($urandom_range(0, 1)), W'($urandom),
            ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 99) == 0));
    end

    // Final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
